// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - game-flow controller: title, song select, beat countdown, play, pause, game over
module game_flow_fsm #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int TITLE_TICKS     = 5000,
  parameter int COUNTDOWN_BEATS = 6,
  parameter int BEAT_TICKS      = 1000,
  parameter int NUM_SONGS       = 4,
  parameter int LEN_W           = 20,
  parameter int TIMER_W         = 24,
  localparam int SEL_W          = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int BEAT_W         = $clog2(COUNTDOWN_BEATS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_n,
  input  logic                       pause_n,
  input  logic                       select_n,
  input  logic [NUM_SONGS*LEN_W-1:0] song_len,
  output logic [2:0]                 state,
  output logic [SEL_W-1:0]           song_sel,
  output logic [TIMER_W-1:0]         elapsed,
  output logic                       tick_pulse,
  output logic                       beat_pulse,
  output logic [BEAT_W-1:0]          beat_idx,
  output logic                       title_screen_en,
  output logic                       title_audio_en,
  output logic                       countdown_en,
  output logic                       song_en,
  output logic                       game_active,
  output logic                       pause_screen,
  output logic                       game_over
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = $clog2(DIV);
  localparam int BCNT_W = $clog2(BEAT_TICKS + 1);

  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(DIV - 1);
  localparam logic [BCNT_W-1:0]  BCNT_MAX  = BCNT_W'(BEAT_TICKS - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(COUNTDOWN_BEATS - 1);
  localparam logic [TIMER_W-1:0] TITLE_END = TIMER_W'(TITLE_TICKS);
  localparam logic [TIMER_W-1:0] CD_END    = TIMER_W'(COUNTDOWN_BEATS * BEAT_TICKS);
  localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAYING   = 3'd3,
    ST_PAUSED    = 3'd4,
    ST_GAMEOVER  = 3'd5
  } state_t;

  state_t state_q, state_d, ret_q;

  logic              start_q, pause_q, select_q;
  logic              start_press, pause_press, select_press;
  logic [PRE_W-1:0]  presc_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [LEN_W-1:0]  len_q, sel_len;
  logic              cd_first_q, beat_due_q;
  logic              counting, resume, clear_cnt, beat_step, cd_start;

  assign state        = state_q;
  assign start_press  = start_q & ~start_n;
  assign pause_press  = pause_q & ~pause_n;
  assign select_press = select_q & ~select_n;

  assign counting   = (state_q == ST_STARTUP) || (state_q == ST_COUNTDOWN) || (state_q == ST_PLAYING);
  assign tick_pulse = counting && (presc_q == PRE_MAX);
  assign beat_pulse = (state_q == ST_COUNTDOWN) && (cd_first_q || beat_due_q);
  assign beat_step  = (state_q == ST_COUNTDOWN) && tick_pulse && (bcnt_q == BCNT_MAX) && (beat_idx != LAST_BEAT);
  assign cd_start   = (state_q == ST_IDLE) && (state_d == ST_COUNTDOWN);

  // Timers survive pause entry and resume so the tick phase is not lost.
  assign resume    = (state_q == ST_PAUSED) && (state_d == ret_q);
  assign clear_cnt = ((state_d != state_q) && (state_d != ST_PAUSED) && !resume)
                   || (state_q == ST_IDLE) || (state_q == ST_GAMEOVER);

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      if (song_sel == SEL_W'(i)) sel_len = song_len[i*LEN_W +: LEN_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_STARTUP;
      ret_q    <= ST_COUNTDOWN;
      start_q  <= 1'b1;
      pause_q  <= 1'b1;
      select_q <= 1'b1;
      song_sel <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_n;
      pause_q  <= pause_n;
      select_q <= select_n;
      if (state_q == ST_IDLE) begin
        if (start_press) len_q <= sel_len;
        else if (select_press) song_sel <= (song_sel == SEL_LAST) ? '0 : song_sel + 1'b1;
      end
      if ((state_d == ST_PAUSED) && (state_q != ST_PAUSED)) ret_q <= state_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    title_screen_en = 1'b0;
    title_audio_en  = 1'b0;
    countdown_en    = 1'b0;
    song_en         = 1'b0;
    game_active     = 1'b0;
    pause_screen    = 1'b0;
    game_over       = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        title_screen_en = 1'b1;
        title_audio_en  = 1'b1;
        if (elapsed >= TITLE_END) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        title_screen_en = 1'b1;
        if (start_press) state_d = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        countdown_en = 1'b1;
        if (elapsed >= CD_END) state_d = ST_PLAYING;
        else if (pause_press) state_d = ST_PAUSED;
      end
      ST_PLAYING: begin
        song_en     = 1'b1;
        game_active = 1'b1;
        if (elapsed >= TIMER_W'(len_q)) state_d = ST_GAMEOVER;
        else if (pause_press) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        pause_screen = 1'b1;
        if (start_press) state_d = ST_IDLE;
        else if (pause_press) state_d = ret_q;
      end
      ST_GAMEOVER: begin
        game_over = 1'b1;
        if (start_press) state_d = ST_IDLE;
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      elapsed    <= '0;
      bcnt_q     <= '0;
      beat_idx   <= '0;
      beat_due_q <= 1'b0;
      cd_first_q <= 1'b0;
    end else begin
      cd_first_q <= cd_start;
      if (clear_cnt) begin
        presc_q <= '0;
        elapsed <= '0;
        bcnt_q  <= '0;
      end else if (counting) begin
        presc_q <= tick_pulse ? '0 : presc_q + 1'b1;
        if (tick_pulse && (elapsed != '1)) elapsed <= elapsed + 1'b1;
        if (tick_pulse && (state_q == ST_COUNTDOWN)) bcnt_q <= (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + 1'b1;
      end
      // A beat crossed on the edge into PAUSED stays pending until resume.
      if (cd_start) begin
        beat_idx   <= '0;
        beat_due_q <= 1'b0;
      end else if (state_q == ST_COUNTDOWN) begin
        beat_due_q <= beat_step;
        if (beat_step) beat_idx <= beat_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb/tb_game_flow_fsm.sv - directed self-checking bench for game_flow_fsm
module tb_game_flow_fsm;

  localparam int LEN_W = 8;
  localparam int TIMER_W = 12;
  localparam int NUM_SONGS = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_n = 1'b1;
  logic pause_n = 1'b1;
  logic select_n = 1'b1;
  logic [NUM_SONGS*LEN_W-1:0] song_len;
  logic [2:0] state;
  logic [1:0] song_sel;
  logic [TIMER_W-1:0] elapsed;
  logic tick_pulse, beat_pulse;
  logic [1:0] beat_idx;
  logic title_screen_en, title_audio_en, countdown_en, song_en, game_active, pause_screen, game_over;

  int n_pass = 0;
  int n_total = 0;

  game_flow_fsm #(
    .CLK_HZ(4), .TICK_HZ(1), .TITLE_TICKS(3), .COUNTDOWN_BEATS(3), .BEAT_TICKS(2),
    .NUM_SONGS(NUM_SONGS), .LEN_W(LEN_W), .TIMER_W(TIMER_W)
  ) dut (
    .clock(clock), .reset(reset), .start_n(start_n), .pause_n(pause_n), .select_n(select_n),
    .song_len(song_len), .state(state), .song_sel(song_sel), .elapsed(elapsed),
    .tick_pulse(tick_pulse), .beat_pulse(beat_pulse), .beat_idx(beat_idx),
    .title_screen_en(title_screen_en), .title_audio_en(title_audio_en), .countdown_en(countdown_en),
    .song_en(song_en), .game_active(game_active), .pause_screen(pause_screen), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic press(input bit s, input bit p, input bit sel);
    start_n = ~s;
    pause_n = ~p;
    select_n = ~sel;
    step(1);
    start_n = 1'b1;
    pause_n = 1'b1;
    select_n = 1'b1;
  endtask

  function automatic logic [6:0] enables();
    return {title_screen_en, title_audio_en, countdown_en, song_en, game_active, pause_screen, game_over};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_elapsed"}, elapsed, 0);
    check({tag, "_song_sel"}, song_sel, 0);
    check({tag, "_beat_idx"}, beat_idx, 0);
    check({tag, "_enables"}, enables(), 7'b1100000);
    check({tag, "_strobes"}, {tick_pulse, beat_pulse}, 0);
  endtask

  initial begin
    int cycles;
    int pulses;
    int bad;
    // song3=50, song2=100, song1=0, song0=10
    song_len = {8'd50, 8'd100, 8'd0, 8'd10};

    step(3);
    reset = 1'b0;
    check_reset_state("rst");

    // title: tick every 4th clock, IDLE after the 13th edge
    for (int k = 1; k <= 13; k++) begin
      step(1);
      if (k < 13) check("title_tick", tick_pulse, (k % 4) == 3);
      check("title_state", state, (k < 13) ? 0 : 1);
    end
    check("idle_enables", enables(), 7'b1000000);
    check("idle_elapsed", elapsed, 0);

    // song select wraps, held key acts once
    for (int i = 0; i < 5; i++) begin
      press(0, 0, 1);
      step(1);
    end
    check("sel_five", song_sel, 1);
    select_n = 1'b0;
    step(50);
    check("sel_hold", song_sel, 2);
    select_n = 1'b1;
    step(1);
    check("sel_release", song_sel, 2);
    check("sel_state", state, 1);

    // countdown: 3 beats, PLAYING 25 edges after entry
    press(1, 0, 0);
    check("cd_state", state, 2);
    check("cd_first_beat", beat_pulse, 1);
    check("cd_first_idx", beat_idx, 0);
    check("cd_enables", enables(), 7'b0010000);
    pulses = 1;
    cycles = 0;
    while (state != 3 && cycles < 100) begin
      step(1);
      cycles++;
      if (beat_pulse) begin
        check("cd_beat_idx", beat_idx, pulses);
        pulses++;
      end
    end
    check("cd_cycles", cycles, 25);
    check("cd_beats", pulses, 3);
    check("play_enables", enables(), 7'b0001100);
    check("play_elapsed", elapsed, 0);

    // pause held, resume keeps phase, abort to IDLE
    step(20);
    check("play_el5", elapsed, 5);
    step(1);
    pause_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (state != 4) bad++;
    end
    check("pause_hold_state", bad, 0);
    check("pause_elapsed", elapsed, 5);
    check("pause_enables", enables(), 7'b0000010);
    check("pause_tick", tick_pulse, 0);
    pause_n = 1'b1;
    step(1);
    check("pause_release", state, 4);
    press(0, 1, 0);
    check("resume_state", state, 3);
    check("resume_elapsed", elapsed, 5);
    check("resume_tick0", tick_pulse, 0);
    step(1);
    check("resume_tick1", tick_pulse, 1);
    check("resume_el_hold", elapsed, 5);
    step(1);
    check("resume_el6", elapsed, 6);
    press(0, 1, 0);
    check("repause_state", state, 4);
    step(1);
    press(1, 1, 0);
    check("abort_state", state, 1);
    check("abort_elapsed", elapsed, 0);
    check("abort_song_sel", song_sel, 2);

    // timeout beats pause; zero length ends at once
    step(1);
    press(0, 0, 1);
    step(1);
    press(0, 0, 1);
    check("sel_wrap", song_sel, 0);
    step(1);
    press(1, 0, 0);
    step(25);
    check("s0_playing", state, 3);
    cycles = 0;
    while (elapsed != 10 && cycles < 100) begin
      step(1);
      cycles++;
    end
    check("s0_el10", elapsed, 10);
    pause_n = 1'b0;
    step(1);
    pause_n = 1'b1;
    check("timeout_wins", state, 5);
    check("gameover_enables", enables(), 7'b0000001);
    check("gameover_elapsed", elapsed, 0);
    press(1, 0, 0);
    check("go_to_idle", state, 1);
    step(1);
    press(0, 0, 1);
    check("sel_one", song_sel, 1);
    step(1);
    press(1, 0, 1);
    check("start_wins_state", state, 2);
    check("start_wins_sel", song_sel, 1);
    step(25);
    check("len0_playing", state, 3);
    step(1);
    check("len0_gameover", state, 5);

    // reset during PLAYING with a pending press
    press(1, 0, 0);
    step(1);
    press(0, 0, 1);
    step(1);
    press(1, 0, 0);
    step(35);
    check("pre_rst_play", state, 3);
    reset = 1'b1;
    pause_n = 1'b0;
    step(1);
    reset = 1'b0;
    pause_n = 1'b1;
    check_reset_state("rst_play");

    // reset during PAUSED mid-countdown
    step(13);
    check("re_idle", state, 1);
    press(0, 0, 1);
    step(1);
    press(1, 0, 0);
    step(10);
    press(0, 1, 0);
    check("cd_pause_state", state, 4);
    check("cd_pause_beat", beat_idx, 1);
    check("cd_pause_sel", song_sel, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset_state("rst_pause");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
